hpdcache_mem_refill_responder: RTL and testbench
================================================

HPDCACHE_MEM_REFILL_RESPONDER -- requirements
Module: hpdcache_mem_refill_responder

Interface
REQ-001 The block SHALL have parameter PA_WIDTH, default 56, physical address width in bits.
REQ-002 The block SHALL have parameter ID_WIDTH, default 4, request/response transaction ID width.
REQ-003 The block SHALL have parameter BEAT_WIDTH, default 64, response data bits per beat (power of 2, >=8).
REQ-004 The block SHALL have parameter CL_BEATS, default 2, beats per cache line (power of 2, >=2).
REQ-005 The block SHALL have parameter REQ_FIFO_DEPTH, default 2, pending refill requests held (>=1).
REQ-006 The block SHALL have a single clock and a synchronous, active-high reset: clk_i is the clock and rst_i is the reset.
REQ-007 The block SHALL have these ports: clk_i in 1, clock; rst_i in 1, synchronous active-high reset.
REQ-008 The block SHALL have these request ports: mem_req_valid_i in 1; mem_req_ready_o out 1; mem_req_addr_i in PA_WIDTH, byte address; mem_req_id_i in ID_WIDTH.
REQ-009 The block SHALL have these backing-store ports: ram_req_o out 1; ram_addr_o out PA_WIDTH-log2(BEAT_WIDTH/8), beat-granular address; ram_rdata_i in BEAT_WIDTH; ram_error_i in 1.
REQ-010 The block SHALL have these response ports: mem_resp_valid_o out 1; mem_resp_ready_i in 1; mem_resp_data_o out BEAT_WIDTH; mem_resp_id_o out ID_WIDTH; mem_resp_last_o out 1; mem_resp_error_o out 1.

Function
REQ-011 The block SHALL accept a request on a cycle where mem_req_valid_i and mem_req_ready_o are both high, and SHALL push {line address, beat offset, id} into the request FIFO.
REQ-012 The block SHALL drive mem_req_ready_o = !fifo_full && !rst_i, and SHALL NOT accept a push into a full FIFO on the same cycle as a pop.
REQ-013 The block SHALL define line address = mem_req_addr_i[PA_WIDTH-1:log2(CL_BEATS*BEAT_WIDTH/8)], and beat offset = the next log2(CL_BEATS) bits below it.
REQ-014 The block SHALL implement the FSM IDLE -> RD -> RSP: IDLE->RD when the FIFO is non-empty, popping the head; RD->RSP unconditionally; RSP->RD on response handshake when the beat is not last; RSP->IDLE on handshake of the last beat.
REQ-015 The block SHALL assert ram_req_o only in RD, with ram_addr_o = {line address, current beat index}.
REQ-016 The block SHALL register ram_rdata_i and ram_error_i at the end of RD, one cycle after ram_req_o; the backing store has a fixed 1-cycle read latency.
REQ-017 The block SHALL assert mem_resp_valid_o only in RSP, and SHALL hold data, id, last and error stable until mem_resp_ready_i is high.
REQ-018 The block SHALL deliver CL_BEATS beats per request in ascending index order, modulo CL_BEATS, assert mem_resp_last_o only on the final beat, and give each beat the request's id.
REQ-019 The block SHALL make mem_resp_error_o sticky within a line: once ram_error_i is seen on a beat, that beat and all later beats of the same line report error=1; the flag clears at line start.
REQ-020 Throughput SHALL be one beat per 2 cycles with a ready sink; the minimum latency from request handshake to first mem_resp_valid_o SHALL be 3 cycles (FIFO, RD, RSP).
REQ-021 The block SHALL process requests strictly in FIFO order and SHALL NOT interleave beats of different lines.

Reset
REQ-022 While rst_i is high, the block SHALL clear the FSM to IDLE, empty the FIFO, clear the beat counter and error flag, and drive mem_resp_valid_o=0, ram_req_o=0, mem_req_ready_o=0, mem_resp_last_o=0, mem_resp_error_o=0.
REQ-023 A reset mid-line SHALL discard the remaining beats and all queued requests, with no response emitted after rst_i falls unless a new request is accepted.

Configuration
REQ-024 With HPDCACHE_REFILL_CRITICAL_WORD_FIRST_EN defined, the first beat index SHALL be the request beat offset, wrapping from CL_BEATS-1 to 0; mem_resp_last_o SHALL mark the CL_BEATS-th beat (index offset-1 mod CL_BEATS).
REQ-025 Without HPDCACHE_REFILL_CRITICAL_WORD_FIRST_EN, the beat offset SHALL be ignored and the first beat index SHALL always be 0.

Verification
REQ-026 Single request, addr=0x1008, id=3, ready held high -> ram_addr_o 0x200, 0x201 (macro off), or 0x201, 0x200 (macro on); two beats with id=3, last on the 2nd; first valid 3 cycles after accept.
REQ-027 Three back-to-back requests, REQ_FIFO_DEPTH=2, sink stalled -> ready low after 2 accepts plus 1 in flight; responses in id order; ready rises the cycle after a pop.
REQ-028 Sink holds mem_resp_ready_i=0 for 5 cycles in RSP -> valid, data and last stable all 5 cycles; no ram_req_o issued.
REQ-029 ram_error_i=1 on beat 0 only -> mem_resp_error_o=1 on beats 0 and 1; next line error=0.
REQ-030 rst_i asserted for 1 cycle after beat 0 handshake -> no further valid; mem_req_ready_o=1 the cycle after reset falls.

Source files
------------

// File: rtl/hpdcache_mem_refill_responder.sv
`timescale 1ns/1ps
// Refill responder: queues cache-line read requests and returns each line beat by beat from a
// backing store with a fixed 1-cycle read latency. Optional macro HPDCACHE_REFILL_CRITICAL_WORD_FIRST_EN.
module hpdcache_mem_refill_responder #(
  parameter int unsigned PA_WIDTH       = 56,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned BEAT_WIDTH     = 64,
  parameter int unsigned CL_BEATS       = 2,
  parameter int unsigned REQ_FIFO_DEPTH = 2
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         mem_req_valid_i,
  output logic                                         mem_req_ready_o,
  input  logic [PA_WIDTH-1:0]                          mem_req_addr_i,
  input  logic [ID_WIDTH-1:0]                          mem_req_id_i,
  output logic                                         ram_req_o,
  output logic [PA_WIDTH-$clog2(BEAT_WIDTH/8)-1:0]     ram_addr_o,
  input  logic [BEAT_WIDTH-1:0]                        ram_rdata_i,
  input  logic                                         ram_error_i,
  output logic                                         mem_resp_valid_o,
  input  logic                                         mem_resp_ready_i,
  output logic [BEAT_WIDTH-1:0]                        mem_resp_data_o,
  output logic [ID_WIDTH-1:0]                          mem_resp_id_o,
  output logic                                         mem_resp_last_o,
  output logic                                         mem_resp_error_o
);

  localparam int unsigned BYTE_OFF_W = $clog2(BEAT_WIDTH / 8);
  localparam int unsigned BEAT_IDX_W = $clog2(CL_BEATS);
  localparam int unsigned LINE_W     = PA_WIDTH - BYTE_OFF_W - BEAT_IDX_W;
  localparam int unsigned PTR_W      = (REQ_FIFO_DEPTH > 1) ? $clog2(REQ_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W      = $clog2(REQ_FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RD, RSP} state_e;

  typedef struct packed {
    logic [LINE_W-1:0]     line;
    logic [BEAT_IDX_W-1:0] off;
    logic [ID_WIDTH-1:0]   id;
  } req_t;

  state_e                state_q, state_d;
  req_t                  fifo_q [REQ_FIFO_DEPTH];
  req_t                  push_entry, head;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  fifo_full, fifo_empty, push, pop;
  logic [LINE_W-1:0]     cur_line_q;
  logic [BEAT_IDX_W-1:0] cur_start_q, beat_cnt_q, first_idx;
  logic [ID_WIDTH-1:0]   cur_id_q;
  logic [BEAT_WIDTH-1:0] rdata_q;
  logic                  err_q, beat_last;
  logic                  unused_byte_off;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(REQ_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign unused_byte_off = ^mem_req_addr_i[BYTE_OFF_W-1:0];

  assign fifo_full       = (count_q == CNT_W'(REQ_FIFO_DEPTH));
  assign fifo_empty      = (count_q == '0);
  assign mem_req_ready_o = !fifo_full && !rst_i;
  assign push            = mem_req_valid_i && mem_req_ready_o;
  assign push_entry      = '{line: mem_req_addr_i[PA_WIDTH-1 -: LINE_W],
                             off:  mem_req_addr_i[BYTE_OFF_W +: BEAT_IDX_W],
                             id:   mem_req_id_i};
  assign head            = fifo_q[rd_ptr_q];

`ifdef HPDCACHE_REFILL_CRITICAL_WORD_FIRST_EN
  assign first_idx = head.off;
`else
  assign first_idx = '0;
`endif

  // Beat count is relative to the first beat, so the wrap and the last marker work for any start index.
  assign beat_last = (beat_cnt_q == BEAT_IDX_W'(CL_BEATS - 1));

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        state_d = RD;
      end
      RD:  state_d = RSP;
      RSP: if (mem_resp_ready_i) state_d = beat_last ? IDLE : RD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
      if (pop) begin
        beat_cnt_q <= '0;
        err_q      <= 1'b0;
      end
      if (state_q == RD) err_q <= err_q | ram_error_i;
      if (state_q == RSP && mem_resp_ready_i && !beat_last) beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= push_entry;
    if (pop) begin
      cur_line_q  <= head.line;
      cur_start_q <= first_idx;
      cur_id_q    <= head.id;
    end
    if (state_q == RD) rdata_q <= ram_rdata_i;
  end

  assign ram_req_o        = (state_q == RD) && !rst_i;
  assign ram_addr_o       = {cur_line_q, cur_start_q + beat_cnt_q};
  assign mem_resp_valid_o = (state_q == RSP) && !rst_i;
  assign mem_resp_data_o  = rdata_q;
  assign mem_resp_id_o    = cur_id_q;
  assign mem_resp_last_o  = mem_resp_valid_o && beat_last;
  assign mem_resp_error_o = mem_resp_valid_o && err_q;

endmodule

// File: tb/tb_hpdcache_mem_refill_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for the refill responder: expected beats are queued on request acceptance and
// compared by monitors whenever the DUT hands out a response beat or a backing-store read.
module tb_hpdcache_mem_refill_responder;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          mem_req_valid_i = 1'b0;
  logic          mem_req_ready_o;
  logic [55:0]   mem_req_addr_i = '0;
  logic [3:0]    mem_req_id_i = '0;
  logic          ram_req_o;
  logic [52:0]   ram_addr_o;
  logic [63:0]   ram_rdata_i;
  logic          ram_error_i;
  logic          mem_resp_valid_o;
  logic          mem_resp_ready_i = 1'b1;
  logic [63:0]   mem_resp_data_o;
  logic [3:0]    mem_resp_id_o;
  logic          mem_resp_last_o;
  logic          mem_resp_error_o;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  id;
    logic        last;
    logic        err;
  } resp_t;

  resp_t       resp_q[$];
  logic [52:0] ram_q[$];
  resp_t       mon_resp;
  logic [52:0] mon_ram;
  int          checks = 0;
  int          failures = 0;
  logic        err_en = 1'b0;
  logic [52:0] err_addr = '0;

  hpdcache_mem_refill_responder #(
    .PA_WIDTH(56), .ID_WIDTH(4), .BEAT_WIDTH(64), .CL_BEATS(2), .REQ_FIFO_DEPTH(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_req_valid_i(mem_req_valid_i), .mem_req_ready_o(mem_req_ready_o),
    .mem_req_addr_i(mem_req_addr_i), .mem_req_id_i(mem_req_id_i),
    .ram_req_o(ram_req_o), .ram_addr_o(ram_addr_o),
    .ram_rdata_i(ram_rdata_i), .ram_error_i(ram_error_i),
    .mem_resp_valid_o(mem_resp_valid_o), .mem_resp_ready_i(mem_resp_ready_i),
    .mem_resp_data_o(mem_resp_data_o), .mem_resp_id_o(mem_resp_id_o),
    .mem_resp_last_o(mem_resp_last_o), .mem_resp_error_o(mem_resp_error_o)
  );

  always #5 clk_i = ~clk_i;

  // Backing store contents are a fixed function of the beat address; errors hit one chosen address.
  function automatic logic [63:0] beat_data(input logic [52:0] a);
    return {a[31:0] ^ 32'h5A5A_5A5A, a[31:0]};
  endfunction

  assign ram_rdata_i = ram_req_o ? beat_data(ram_addr_o) : 64'h0;
  assign ram_error_i = ram_req_o && err_en && (ram_addr_o == err_addr);

  task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushExpected(input logic [55:0] addr, input logic [3:0] id);
    logic [51:0] line;
    logic        start;
    logic        idx;
    logic        sticky;
    logic [52:0] ra;
    resp_t       r;
    line = addr[55:4];
`ifdef HPDCACHE_REFILL_CRITICAL_WORD_FIRST_EN
    start = addr[3];
`else
    start = 1'b0;
`endif
    sticky = 1'b0;
    for (int k = 0; k < 2; k++) begin
      idx    = start ^ k[0];
      ra     = {line, idx};
      sticky = sticky | (err_en && (ra == err_addr));
      r.data = beat_data(ra);
      r.id   = id;
      r.last = (k == 1);
      r.err  = sticky;
      resp_q.push_back(r);
      ram_q.push_back(ra);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the accept edge.
  task automatic applyStimulus(input logic [55:0] addr, input logic [3:0] id);
    int waited;
    waited          = 0;
    mem_req_valid_i = 1'b1;
    mem_req_addr_i  = addr;
    mem_req_id_i    = id;
    @(negedge clk_i);
    while (!mem_req_ready_o && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    checkOutput("req_accept", 96'(mem_req_ready_o), 96'd1);
    if (mem_req_ready_o) pushExpected(addr, id);
    @(posedge clk_i);
    #1;
    mem_req_valid_i = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || ram_q.size() != 0) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("drain", 96'(resp_q.size() + ram_q.size()), 96'd0);
    resp_q.delete();
    ram_q.delete();
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && mem_resp_valid_o && mem_resp_ready_i) begin
      checkOutput("resp_expected", 96'(resp_q.size() != 0), 96'd1);
      if (resp_q.size() != 0) begin
        mon_resp = resp_q.pop_front();
        checkOutput("resp_data", 96'(mem_resp_data_o), 96'(mon_resp.data));
        checkOutput("resp_id", 96'(mem_resp_id_o), 96'(mon_resp.id));
        checkOutput("resp_last", 96'(mem_resp_last_o), 96'(mon_resp.last));
        checkOutput("resp_error", 96'(mem_resp_error_o), 96'(mon_resp.err));
      end
    end
    if (!rst_i && ram_req_o) begin
      checkOutput("ram_expected", 96'(ram_q.size() != 0), 96'd1);
      if (ram_q.size() != 0) begin
        mon_ram = ram_q.pop_front();
        checkOutput("ram_addr", 96'(ram_addr_o), 96'(mon_ram));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int vcount;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("reset_outputs",
                96'({mem_req_ready_o, mem_resp_valid_o, ram_req_o, mem_resp_last_o, mem_resp_error_o}), 96'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("ready_after_reset", 96'(mem_req_ready_o), 96'd1);
    @(posedge clk_i);
    #1;

    // Single request: line 0x100, two beats, first valid three cycles after accept.
    applyStimulus(56'h1008, 4'd3);
    k = 1;
    while (k < 20) begin
      @(negedge clk_i);
      if (mem_resp_valid_o) break;
      k++;
    end
    checkOutput("first_valid_latency", 96'(k), 96'd3);
    waitDrain();

    // Three requests with a stalled sink: one in flight plus two queued fills the FIFO.
    mem_resp_ready_i = 1'b0;
    applyStimulus(56'h1100, 4'd1);
    applyStimulus(56'h1140, 4'd2);
    applyStimulus(56'h1180, 4'd4);
    @(negedge clk_i);
    checkOutput("ready_full", 96'(mem_req_ready_o), 96'd0);
    repeat (3) @(negedge clk_i);
    checkOutput("ready_full_held", 96'(mem_req_ready_o), 96'd0);
    @(posedge clk_i);
    #1 mem_resp_ready_i = 1'b1;
    k = 0;
    while (k < 20) begin
      @(negedge clk_i);
      if (mem_req_ready_o) break;
      k++;
    end
    checkOutput("ready_rise_delay", 96'(k), 96'd4);
    waitDrain();

    // Sink stall for five cycles on the first beat of line 0x124.
    mem_resp_ready_i = 1'b0;
    applyStimulus(56'h1240, 4'd9);
    k = 0;
    while (!mem_resp_valid_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk_i);
      checkOutput("stall_hold",
                  96'({mem_resp_valid_o, ram_req_o, mem_resp_last_o, mem_resp_id_o, mem_resp_data_o}),
                  96'({1'b1, 1'b0, 1'b0, 4'd9, beat_data(53'h248)}));
    end
    @(posedge clk_i);
    #1 mem_resp_ready_i = 1'b1;
    waitDrain();

    // Error on beat 0 sticks for the line; the next line is clean; error on beat 1 spares beat 0.
    err_en   = 1'b1;
    err_addr = 53'h400;
    applyStimulus(56'h2000, 4'd5);
    applyStimulus(56'h2040, 4'd6);
    waitDrain();
    err_addr = 53'h411;
    applyStimulus(56'h2080, 4'd11);
    waitDrain();
    err_en = 1'b0;

    // Reset right after the first beat handshake drops the rest of the line and the queued request.
    applyStimulus(56'h3000, 4'd7);
    applyStimulus(56'h3040, 4'd8);
    k = 0;
    while (!(mem_resp_valid_o && mem_resp_ready_i) && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    checkOutput("midline_first_beat", 96'(mem_resp_valid_o), 96'd1);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    resp_q.delete();
    ram_q.delete();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("ready_after_midline_reset", 96'(mem_req_ready_o), 96'd1);
    vcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_resp_valid_o || ram_req_o) vcount++;
      @(negedge clk_i);
    end
    checkOutput("no_activity_after_reset", 96'(vcount), 96'd0);
    @(posedge clk_i);
    #1;

    // A fresh request after reset is served normally.
    applyStimulus(56'h1008, 4'd10);
    waitDrain();

    checkOutput("scoreboard_empty", 96'(resp_q.size() + ram_q.size()), 96'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
